// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, mask layout,
// port indices and the read-owner pipeline record.
package dmem_pkg;

  // Arbiter FSM encoding
  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Write mask layout: bit UPPER_WORD enables the upper 32 bits, bits 3:0 are byte lanes
  localparam int unsigned UPPER_WORD = 4;
  localparam int unsigned MASK_W     = UPPER_WORD + 1;

  // Requester indices as carried in the read-owner pipe
  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DMA = 1'b1;

  typedef struct packed {
    logic valid;
    logic port;
  } rd_owner_t;

  // A write only touches memory when at least one lane is enabled
  function automatic logic mask_writes(input logic we, input logic [MASK_W-1:0] mask);
    return we && (mask != '0);
  endfunction

endpackage

// File: rtl/dmem_starve_ctr.sv
// Saturating counter of consecutive port-0 grants while port 1 is waiting.
// hold dominates clear, clear dominates increment. MAX_WAIT must be at least 1.
module dmem_starve_ctr #(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic inc_i,
  input  logic clr_i,
  input  logic hold_i,
  output logic expired_o
);

  localparam int unsigned      CNT_W   = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: frozen while held, cleared on demand, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (!hold_i) begin
      if (clr_i) begin
        cnt_d = '0;
      end else if (inc_i && (cnt_q != CNT_MAX)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Count register with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == CNT_MAX);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the single-port data RAM.
// Port 0 (pipeline MEM stage) has fixed priority; port 1 (loader/debug DMA)
// is guaranteed a grant after MAX_WAIT consecutive port-0 grants. A lock held
// by port 0 keeps AMO read-modify-write sequences atomic. Port-1 writes are
// reported one cycle later as snoop events for the LR/SC reservation.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   ST_IDLE   | normal arbitration, starvation guard active
//   ST_LOCKED | AMO in progress: only port 0 is served, wait count frozen
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned RD_LAT   = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              p0_req_i,
  input  logic              p0_we_i,
  input  logic              p0_lock_i,
  input  logic [ADDR_W-1:0] p0_addr_i,
  input  logic [63:0]       p0_wdata_i,
  input  logic [MASK_W-1:0] p0_wmask_i,
  output logic              p0_gnt_o,
  output logic              p0_stall_o,
  output logic              p0_rvalid_o,
  input  logic              p1_req_i,
  input  logic              p1_we_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic [63:0]       p1_wdata_i,
  input  logic [MASK_W-1:0] p1_wmask_i,
  output logic              p1_gnt_o,
  output logic              p1_rvalid_o,
  output logic [63:0]       rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [63:0]       mem_wdata_o,
  output logic [MASK_W-1:0] mem_wmask_o,
  output logic              mem_en_o,
  input  logic [63:0]       mem_rdata_i,
  output logic              snoop_valid_o,
  output logic [ADDR_W-1:0] snoop_addr_o
);

  logic [0:0]        state_q;
  logic [0:0]        state_d;
  logic              p0_gnt;
  logic              p1_gnt;
  logic              starve_expired;
  rd_owner_t         rd_owner_q [RD_LAT];
  rd_owner_t         rd_owner_d [RD_LAT];
  rd_owner_t         rd_tail;
  logic              snoop_valid_q;
  logic              snoop_valid_d;
  logic [ADDR_W-1:0] snoop_addr_q;
  logic [ADDR_W-1:0] snoop_addr_d;

  dmem_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve_ctr (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .inc_i     (p0_gnt & p1_req_i),
    .clr_i     (p1_gnt | ~p1_req_i),
    .hold_i    (state_q == ST_LOCKED),
    .expired_o (starve_expired)
  );

  // Zero-latency grant decision; nothing is granted while reset is held
  always_comb begin
    p0_gnt = 1'b0;
    p1_gnt = 1'b0;
    if (reset_i) begin
      if (state_q == ST_LOCKED) begin
        p0_gnt = p0_req_i;
      end else if (p0_req_i && p1_req_i) begin
        p0_gnt = ~starve_expired;
        p1_gnt = starve_expired;
      end else begin
        p0_gnt = p0_req_i;
        p1_gnt = p1_req_i;
      end
    end
  end

  // Lock follows p0_lock_i on every granted port-0 access
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (p0_gnt && p0_lock_i)  state_d = ST_LOCKED;
      ST_LOCKED: if (p0_gnt && !p0_lock_i) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Route the granted port onto the RAM interface; mask stays zero for reads and idle
  always_comb begin
    mem_addr_o  = p0_addr_i;
    mem_wdata_o = p0_wdata_i;
    mem_wmask_o = '0;
    if (p1_gnt) begin
      mem_addr_o  = p1_addr_i;
      mem_wdata_o = p1_wdata_i;
      mem_wmask_o = p1_we_i ? p1_wmask_i : '0;
    end else if (p0_gnt) begin
      mem_wmask_o = p0_we_i ? p0_wmask_i : '0;
    end
  end

  // Read-owner pipe (depth RD_LAT) and snoop capture for port-1 writes
  always_comb begin
    rd_owner_d[0].valid = (p0_gnt & ~p0_we_i) | (p1_gnt & ~p1_we_i);
    rd_owner_d[0].port  = p1_gnt ? PORT_DMA : PORT_CPU;
    for (int unsigned i = 1; i < RD_LAT; i++) begin
      rd_owner_d[i] = rd_owner_q[i-1];
    end
    snoop_valid_d = p1_gnt & mask_writes(p1_we_i, p1_wmask_i);
    snoop_addr_d  = snoop_valid_d ? p1_addr_i : snoop_addr_q;
  end

  // State, read-owner and snoop registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_q       <= ST_IDLE;
      snoop_valid_q <= 1'b0;
      snoop_addr_q  <= '0;
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        rd_owner_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      snoop_valid_q <= snoop_valid_d;
      snoop_addr_q  <= snoop_addr_d;
      rd_owner_q    <= rd_owner_d;
    end
  end

  // Returns are masked while reset is held so an in-flight read is dropped
  assign rd_tail       = rd_owner_q[RD_LAT-1];
  assign p0_rvalid_o   = reset_i & rd_tail.valid & (rd_tail.port == PORT_CPU);
  assign p1_rvalid_o   = reset_i & rd_tail.valid & (rd_tail.port == PORT_DMA);
  assign rdata_o       = mem_rdata_i;
  assign snoop_valid_o = reset_i & snoop_valid_q;
  assign snoop_addr_o  = snoop_addr_q;
  assign p0_gnt_o      = p0_gnt;
  assign p1_gnt_o      = p1_gnt;
  assign mem_en_o      = p0_gnt | p1_gnt;
  assign p0_stall_o    = p0_req_i & ~p0_gnt;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random traffic,
// checked against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;

  localparam int unsigned ADDR_W   = 32;
  localparam int unsigned MAX_WAIT = 4;

  logic              clk_i = 1'b0;
  logic              reset_i = 1'b0;
  logic              p0_req_i = 1'b0, p0_we_i = 1'b0, p0_lock_i = 1'b0;
  logic [ADDR_W-1:0] p0_addr_i = '0;
  logic [63:0]       p0_wdata_i = '0;
  logic [4:0]        p0_wmask_i = '0;
  logic              p1_req_i = 1'b0, p1_we_i = 1'b0;
  logic [ADDR_W-1:0] p1_addr_i = '0;
  logic [63:0]       p1_wdata_i = '0;
  logic [4:0]        p1_wmask_i = '0;
  logic [63:0]       mem_rdata_i = '0;
  logic              p0_gnt_o, p0_stall_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
  logic [63:0]       rdata_o, mem_wdata_o;
  logic [ADDR_W-1:0] mem_addr_o, snoop_addr_o;
  logic [4:0]        mem_wmask_o;
  logic              mem_en_o, snoop_valid_o;

  always #5 clk_i = ~clk_i;

  dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT), .RD_LAT(1)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_lock_i(p0_lock_i),
    .p0_addr_i(p0_addr_i), .p0_wdata_i(p0_wdata_i), .p0_wmask_i(p0_wmask_i),
    .p0_gnt_o(p0_gnt_o), .p0_stall_o(p0_stall_o), .p0_rvalid_o(p0_rvalid_o),
    .p1_req_i(p1_req_i), .p1_we_i(p1_we_i),
    .p1_addr_i(p1_addr_i), .p1_wdata_i(p1_wdata_i), .p1_wmask_i(p1_wmask_i),
    .p1_gnt_o(p1_gnt_o), .p1_rvalid_o(p1_rvalid_o),
    .rdata_o(rdata_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_wmask_o(mem_wmask_o), .mem_en_o(mem_en_o), .mem_rdata_i(mem_rdata_i),
    .snoop_valid_o(snoop_valid_o), .snoop_addr_o(snoop_addr_o)
  );

  typedef struct {
    bit          rst;
    bit          p0_req, p0_we, p0_lock;
    logic [31:0] p0_addr;
    logic [63:0] p0_wdata;
    logic [4:0]  p0_mask;
    bit          p1_req, p1_we;
    logic [31:0] p1_addr;
    logic [63:0] p1_wdata;
    logic [4:0]  p1_mask;
    logic [63:0] rdata;
  } stim_t;

  typedef struct {
    bit          g0, g1, stall, en;
    logic [4:0]  wmask;
    logic [31:0] addr;
    logic [63:0] wdata;
  } cyc_exp_t;

  typedef struct {
    bit          port;
    logic [63:0] data;
  } rd_exp_t;

  cyc_exp_t    cyc_q[$];
  rd_exp_t     rd_q[$];
  logic [31:0] sn_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  // Reference model: lock flag, run of port-0 grants while port 1 waits,
  // and the responses owed in the next cycle.
  bit          m_locked = 0;
  int          m_run = 0;
  bit          pend_rd = 0, pend_port = 0, pend_sn = 0;
  logic [31:0] pend_sn_addr = '0;

  function automatic stim_t idle_stim();
    stim_t s;
    s.rst = 1; s.p0_req = 0; s.p0_we = 0; s.p0_lock = 0;
    s.p0_addr = 32'h0; s.p0_wdata = 64'h0; s.p0_mask = 5'h0;
    s.p1_req = 0; s.p1_we = 0; s.p1_addr = 32'h0; s.p1_wdata = 64'h0; s.p1_mask = 5'h0;
    s.rdata = {$urandom(), $urandom()};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s = idle_stim();
    s.rst      = ($urandom_range(0, 149) != 0);
    s.p0_req   = ($urandom_range(0, 9) < 6);
    s.p0_we    = 1'($urandom_range(0, 1));
    s.p0_lock  = ($urandom_range(0, 9) < 2);
    s.p0_addr  = $urandom() & 32'h0000_fff8;
    s.p0_wdata = {$urandom(), $urandom()};
    s.p0_mask  = 5'($urandom());
    s.p1_req   = ($urandom_range(0, 9) < 5);
    s.p1_we    = 1'($urandom_range(0, 1));
    s.p1_addr  = $urandom() & 32'h0000_fff8;
    s.p1_wdata = {$urandom(), $urandom()};
    s.p1_mask  = ($urandom_range(0, 3) == 0) ? 5'h0 : 5'($urandom());
    return s;
  endfunction

  // Apply one cycle of stimulus and push what the DUT owes for it
  task automatic step(input stim_t s);
    cyc_exp_t e;
    rd_exp_t  r;
    int       g;
    @(posedge clk_i); #1;
    reset_i = s.rst;
    p0_req_i = s.p0_req; p0_we_i = s.p0_we; p0_lock_i = s.p0_lock;
    p0_addr_i = s.p0_addr; p0_wdata_i = s.p0_wdata; p0_wmask_i = s.p0_mask;
    p1_req_i = s.p1_req; p1_we_i = s.p1_we;
    p1_addr_i = s.p1_addr; p1_wdata_i = s.p1_wdata; p1_wmask_i = s.p1_mask;
    mem_rdata_i = s.rdata;

    if (s.rst) begin
      if (pend_rd) begin r.port = pend_port; r.data = s.rdata; rd_q.push_back(r); end
      if (pend_sn) sn_q.push_back(pend_sn_addr);
    end
    pend_rd = 0;
    pend_sn = 0;

    g = -1;
    if (s.rst) begin
      if (m_locked)                 g = s.p0_req ? 0 : -1;
      else if (s.p0_req && s.p1_req) g = (m_run >= MAX_WAIT) ? 1 : 0;
      else if (s.p0_req)             g = 0;
      else if (s.p1_req)             g = 1;
    end

    e.g0    = (g == 0);
    e.g1    = (g == 1);
    e.stall = s.p0_req && (g != 0);
    e.en    = (g >= 0);
    e.addr  = (g == 1) ? s.p1_addr : s.p0_addr;
    e.wdata = (g == 1) ? s.p1_wdata : s.p0_wdata;
    e.wmask = (g == 0) ? (s.p0_we ? s.p0_mask : 5'h0) :
              (g == 1) ? (s.p1_we ? s.p1_mask : 5'h0) : 5'h0;
    cyc_q.push_back(e);

    if (!s.rst) begin
      m_locked = 0;
      m_run    = 0;
    end else begin
      if (g == 0 && !s.p0_we) begin pend_rd = 1; pend_port = 0; end
      if (g == 1 && !s.p1_we) begin pend_rd = 1; pend_port = 1; end
      if (g == 1 && s.p1_we && s.p1_mask != 5'h0) begin pend_sn = 1; pend_sn_addr = s.p1_addr; end
      if (!m_locked) begin
        if (g == 1 || !s.p1_req) m_run = 0;
        else if (g == 0)         m_run = m_run + 1;
      end
      if (g == 0) m_locked = s.p0_lock;
    end
  endtask

  // Monitor: compares grant/RAM side every cycle, read returns and snoops when presented or owed
  initial begin
    cyc_exp_t e;
    rd_exp_t  r;
    logic [31:0] a;
    forever begin
      @(negedge clk_i);
      if (cyc_q.size() > 0) begin
        e = cyc_q.pop_front();
        n_tests++;
        if ({p0_gnt_o, p1_gnt_o, p0_stall_o, mem_en_o} !== {e.g0, e.g1, e.stall, e.en} ||
            mem_wmask_o !== e.wmask ||
            (e.en && (mem_addr_o !== e.addr || mem_wdata_o !== e.wdata))) begin
          n_fail++;
          $display("FAIL grant t=%0t got g0=%b g1=%b stall=%b en=%b mask=%h addr=%h wdata=%h need g0=%b g1=%b stall=%b en=%b mask=%h addr=%h wdata=%h",
                   $time, p0_gnt_o, p1_gnt_o, p0_stall_o, mem_en_o, mem_wmask_o, mem_addr_o, mem_wdata_o,
                   e.g0, e.g1, e.stall, e.en, e.wmask, e.addr, e.wdata);
        end
      end
      if (p0_rvalid_o || p1_rvalid_o || rd_q.size() > 0) begin
        n_tests++;
        if (rd_q.size() == 0) begin
          n_fail++;
          $display("FAIL rvalid t=%0t got p0_rvalid=%b p1_rvalid=%b need none", $time, p0_rvalid_o, p1_rvalid_o);
        end else begin
          r = rd_q.pop_front();
          if (p0_rvalid_o !== 1'(r.port == 0) || p1_rvalid_o !== 1'(r.port == 1) || rdata_o !== r.data) begin
            n_fail++;
            $display("FAIL rdata t=%0t got p0_rvalid=%b p1_rvalid=%b rdata=%h need port%0d rdata=%h",
                     $time, p0_rvalid_o, p1_rvalid_o, rdata_o, r.port, r.data);
          end
        end
      end
      if (snoop_valid_o || sn_q.size() > 0) begin
        n_tests++;
        if (sn_q.size() == 0) begin
          n_fail++;
          $display("FAIL snoop t=%0t got snoop_valid=1 addr=%h need none", $time, snoop_addr_o);
        end else begin
          a = sn_q.pop_front();
          if (snoop_valid_o !== 1'b1 || snoop_addr_o !== a) begin
            n_fail++;
            $display("FAIL snoop t=%0t got valid=%b addr=%h need valid=1 addr=%h", $time, snoop_valid_o, snoop_addr_o, a);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    stim_t s;

    // Reset state
    s = idle_stim(); s.rst = 0; s.p0_req = 1; s.p1_req = 1;
    step(s); step(s);
    step(idle_stim());

    // Port 0 read at 0x100, RAM answers next cycle
    s = idle_stim(); s.p0_req = 1; s.p0_addr = 32'h100;
    step(s);
    s = idle_stim(); s.rdata = 64'h1122_3344_5566_7788;
    step(s);

    // Both ports request every cycle: 0,0,0,0,1,0,0,0,0,1
    for (int i = 0; i < 10; i++) begin
      s = idle_stim(); s.p0_req = 1; s.p0_addr = 32'h800 + 32'(i * 8);
      s.p1_req = 1; s.p1_addr = 32'h900;
      step(s);
    end
    step(idle_stim());

    // AMO: locked read at 0x200, write with lock released, port 1 waiting throughout
    s = idle_stim(); s.p0_req = 1; s.p0_lock = 1; s.p0_addr = 32'h200; s.p1_req = 1; s.p1_addr = 32'h500;
    step(s);
    s = idle_stim(); s.p1_req = 1; s.p1_addr = 32'h500;
    step(s);
    s.p0_req = 1; s.p0_we = 1; s.p0_addr = 32'h200; s.p0_mask = 5'b01111; s.p0_wdata = 64'hdead_beef_0bad_f00d;
    step(s);
    s = idle_stim(); s.p1_req = 1; s.p1_addr = 32'h500;
    step(s);
    step(idle_stim());

    // Port 1 write snoops; port 0 write to the same address does not
    s = idle_stim(); s.p1_req = 1; s.p1_we = 1; s.p1_addr = 32'h300; s.p1_mask = 5'b00001; s.p1_wdata = 64'h55;
    step(s);
    s = idle_stim(); s.p0_req = 1; s.p0_we = 1; s.p0_addr = 32'h300; s.p0_mask = 5'b11111;
    step(s);
    step(idle_stim());

    // Reset while locked with a read in flight
    s = idle_stim(); s.p0_req = 1; s.p0_lock = 1; s.p0_addr = 32'h240;
    step(s);
    s = idle_stim(); s.rst = 0; s.p1_req = 1; s.p1_addr = 32'h600;
    step(s);
    s.rst = 1;
    step(s);
    step(idle_stim());

    // Port 0 write at the starvation boundary, then a lock request at the boundary
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < MAX_WAIT; i++) begin
        s = idle_stim(); s.p0_req = 1; s.p0_addr = 32'h700; s.p1_req = 1; s.p1_addr = 32'h400;
        step(s);
      end
      s = idle_stim(); s.p0_req = 1; s.p0_we = (v == 0); s.p0_lock = (v == 1);
      s.p0_addr = 32'h708; s.p0_mask = 5'b10011; s.p0_wdata = 64'h0123_4567_89ab_cdef;
      s.p1_req = 1; s.p1_we = 1; s.p1_addr = 32'h400; s.p1_mask = 5'b00110; s.p1_wdata = 64'h77;
      step(s);
      s.p1_we = 0;
      step(s);
      s.p0_we = 1; s.p0_lock = 0;
      step(s);
      step(idle_stim());
    end

    // Random traffic
    for (int i = 0; i < 2000; i++) step(rand_stim());
    for (int i = 0; i < 3; i++) step(idle_stim());

    @(posedge clk_i);
    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
